// File: rtl/int_to_fp_seq.sv
// Sequential 32-bit integer to bfloat16 converter, round-to-nearest-even.
// Optional INT_TO_FP_LZC_EN: single-cycle leading-zero count and shift in NORM.
module int_to_fp_seq #(
    parameter bit SIGNED_IN = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] int_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [15:0] fp_o,
    output logic [2:0]  flag_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {S_IDLE, S_NORM, S_ROUND, S_DONE} state_t;

    state_t      r_state;
    logic        r_sign;
    logic [31:0] r_mag;
    logic [4:0]  r_sc;
    logic [15:0] r_fp;
    logic [2:0]  r_flag;
    logic        r_out_valid;
    logic        r_in_ready;
    logic        r_busy;

    logic        w_neg;
    logic [31:0] w_mag_in;
    logic [7:0]  w_exp_base;
    logic        w_g;
    logic        w_s;
    logic        w_up;
    logic [14:0] w_em;

    assign w_neg      = SIGNED_IN & int_i[31];
    assign w_mag_in   = w_neg ? (32'd0 - int_i) : int_i;

    // Rounding works on {exp, mant} so a mantissa carry ripples into the exponent.
    assign w_exp_base = 8'd158 - {3'b000, r_sc};
    assign w_g        = r_mag[23];
    assign w_s        = |r_mag[22:0];
    assign w_up       = w_g & (w_s | r_mag[24]);
    assign w_em       = {w_exp_base, r_mag[30:24]} + {14'd0, w_up};

`ifdef INT_TO_FP_LZC_EN
    function automatic logic [4:0] lzc32(input logic [31:0] v);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) begin
                n = 5'(31 - i);
            end else begin
                n = n;
            end
        end
        return n;
    endfunction

    logic [4:0] w_lzc;
    assign w_lzc = lzc32(r_mag);
`endif

    // Control FSM with all handshake and result outputs registered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_sign      <= 1'b0;
            r_mag       <= 32'd0;
            r_sc        <= 5'd0;
            r_fp        <= 16'd0;
            r_flag      <= 3'b000;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid_i) begin
                        r_sign     <= w_neg;
                        r_mag      <= w_mag_in;
                        r_sc       <= 5'd0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        if (int_i == 32'd0) begin
                            r_fp        <= 16'h0000;
                            r_flag      <= 3'b000;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_state     <= S_NORM;
                        end
                    end
                end
                S_NORM: begin
`ifdef INT_TO_FP_LZC_EN
                    r_mag   <= r_mag << w_lzc;
                    r_sc    <= w_lzc;
                    r_state <= S_ROUND;
`else
                    if (r_mag[31]) begin
                        r_state <= S_ROUND;
                    end else if (r_mag[31:24] == 8'd0) begin
                        r_mag <= {r_mag[23:0], 8'd0};
                        r_sc  <= r_sc + 5'd8;
                    end else begin
                        r_mag <= {r_mag[30:0], 1'b0};
                        r_sc  <= r_sc + 5'd1;
                    end
`endif
                end
                S_ROUND: begin
                    r_fp        <= {r_sign, w_em};
                    r_flag      <= (w_g | w_s) ? 3'b100 : 3'b000;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready_i) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready_o  = r_in_ready;
    assign out_valid_o = r_out_valid;
    assign fp_o        = r_fp;
    assign flag_o      = r_flag;
    assign busy_o      = r_busy;

endmodule

// File: tb/tb_int_to_fp_seq.sv
// Directed bench for int_to_fp_seq: signed and unsigned instances, latency, hold and reset cases.
module tb_int_to_fp_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] int_in = 32'd0;
    logic        out_ready = 1'b0;
    logic        sel = 1'b0;

    logic        s_in_ready, s_out_valid, s_busy;
    logic [15:0] s_fp;
    logic [2:0]  s_flag;
    logic        u_in_ready, u_out_valid, u_busy;
    logic [15:0] u_fp;
    logic [2:0]  u_flag;

    wire         c_in_ready  = sel ? u_in_ready  : s_in_ready;
    wire         c_out_valid = sel ? u_out_valid : s_out_valid;
    wire         c_busy      = sel ? u_busy      : s_busy;
    wire  [15:0] c_fp        = sel ? u_fp        : s_fp;
    wire  [2:0]  c_flag      = sel ? u_flag      : s_flag;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    int_to_fp_seq #(.SIGNED_IN(1'b1)) u_dut_s (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid & ~sel), .in_ready_o(s_in_ready),
        .int_i(int_in), .out_valid_o(s_out_valid), .out_ready_i(out_ready),
        .fp_o(s_fp), .flag_o(s_flag), .busy_o(s_busy)
    );

    int_to_fp_seq #(.SIGNED_IN(1'b0)) u_dut_u (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid & sel), .in_ready_o(u_in_ready),
        .int_i(int_in), .out_valid_o(u_out_valid), .out_ready_i(out_ready),
        .fp_o(u_fp), .flag_o(u_flag), .busy_o(u_busy)
    );

    typedef struct {
        logic [31:0] val;
        bit          uns;
        logic [15:0] fp;
        logic [2:0]  fl;
        int          lat;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Accept one operand, measure latency to out_valid, check result, then drain it.
    task automatic run(input logic [31:0] val, input bit uns, input logic [15:0] efp,
                       input logic [2:0] efl, input int elat, input string name);
        int lat;
        @(negedge clk);
        sel      = uns;
        int_in   = val;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!c_out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, " out_valid"}, {31'd0, c_out_valid}, 32'd1);
        check({name, " fp"}, {16'd0, c_fp}, {16'd0, efp});
        check({name, " flag"}, {29'd0, c_flag}, {29'd0, efl});
        check({name, " latency"}, lat, elat);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, " in_ready after drain"}, {31'd0, c_in_ready}, 32'd1);
    endtask

    initial begin
        int exp_lat;
        vecs[0]  = '{32'h0000_0001, 1'b0, 16'h3F80, 3'b000, 13};
        vecs[1]  = '{32'h8000_0000, 1'b0, 16'hCF00, 3'b000, 3};
        vecs[2]  = '{32'h0000_0000, 1'b0, 16'h0000, 3'b000, 1};
        vecs[3]  = '{32'h7FFF_FFFF, 1'b0, 16'h4F00, 3'b100, 4};
        vecs[4]  = '{32'd257,       1'b0, 16'h4380, 3'b100, 12};
        vecs[5]  = '{32'd259,       1'b0, 16'h4382, 3'b100, 12};
        vecs[6]  = '{32'hFFFF_FEFF, 1'b0, 16'hC380, 3'b100, 12};
        vecs[7]  = '{32'd255,       1'b0, 16'h437F, 3'b000, 6};
        vecs[8]  = '{32'hFFFF_FFFF, 1'b0, 16'hBF80, 3'b000, 13};
        vecs[9]  = '{32'h0100_0001, 1'b0, 16'h4B80, 3'b100, 10};
        vecs[10] = '{32'd1000,      1'b0, 16'h447A, 3'b000, 11};
        vecs[11] = '{32'hFFFF_FFFF, 1'b1, 16'h4F80, 3'b100, 3};
        vecs[12] = '{32'h8000_0000, 1'b1, 16'h4F00, 3'b000, 3};

        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", {31'd0, s_in_ready}, 32'd1);
        check("reset out_valid", {31'd0, s_out_valid}, 32'd0);
        check("reset busy", {31'd0, s_busy}, 32'd0);
        check("reset fp/flag", {13'd0, s_flag, s_fp}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
`ifdef INT_TO_FP_LZC_EN
            exp_lat = (vecs[i].val == 32'd0) ? 1 : 3;
`else
            exp_lat = vecs[i].lat;
`endif
            run(vecs[i].val, vecs[i].uns, vecs[i].fp, vecs[i].fl, exp_lat,
                $sformatf("vec%0d", i));
        end

        // Hold in DONE: result stable, new operand refused.
        @(negedge clk);
        sel = 1'b0; int_in = 32'd5; in_valid = 1'b1;
        @(posedge clk);
        #1;
        int_in = 32'd7;
        for (int k = 0; k < 40 && !s_out_valid; k++) begin
            @(posedge clk);
            #1;
        end
        for (int k = 0; k < 20; k++) begin
            check("hold fp", {16'd0, s_fp}, 32'h0000_40A0);
            check("hold flag/valid/ready", {28'd0, s_flag, s_out_valid & ~s_in_ready}, 32'd1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("release in_ready", {31'd0, s_in_ready}, 32'd1);
        check("release out_valid", {31'd0, s_out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("held operand not consumed", {31'd0, s_busy}, 32'd0);

        // Reset while normalising.
        @(negedge clk);
        int_in = 32'd1; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("busy in NORM", {31'd0, c_busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst out_valid", {31'd0, s_out_valid}, 32'd0);
        check("rst fp", {16'd0, s_fp}, 32'd0);
        check("rst idle", {30'd0, s_in_ready, s_busy}, 32'd2);
`ifdef INT_TO_FP_LZC_EN
        run(32'd3, 1'b0, 16'h4040, 3'b000, 3, "after rst");
`else
        run(32'd3, 1'b0, 16'h4040, 3'b000, 12, "after rst");
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/int_to_fp_seq.md
Name: int_to_fp_seq

Overview:
- Multi-cycle converter from a 32-bit integer to bfloat16 (1 sign, 8 exponent, 7 mantissa bits). Sits directly upstream of the FPU bf16 datapath: it feeds bf16 operands into the FP units and into the bf16-to-int converter.
- Accepts one operand per valid/ready handshake and normalises it iteratively.
- Rounds to nearest, ties to even. Holds the result until the consumer accepts it.

Parameters:
- SIGNED_IN, 1: 1 = int_i is two's complement; 0 = int_i is unsigned.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  synchronous, active-high reset
- in_valid_i  input  1  int_i valid
- in_ready_o  output  1  block can accept an operand
- int_i  input  32  integer operand
- out_valid_o  output  1  fp_o/flag_o valid
- out_ready_i  input  1  consumer accepts the result
- fp_o  output  16  bf16 result
- flag_o  output  3  000 = exact; 100 = inexact (rounded); 001/010 (overflow/underflow) reserved, never produced
- busy_o  output  1  state != IDLE

Behaviour:
- One clock (clk_i). Reset rst_i is synchronous and active-high.
- Reset values: state = IDLE, fp_o = 0, flag_o = 0, out_valid_o = 0, in_ready_o = 1, busy_o = 0.
- FSM states: IDLE, NORM, ROUND, DONE. in_ready_o = (state == IDLE). out_valid_o = (state == DONE). All outputs are registered.
- IDLE, on in_valid_i && in_ready_o:
  - Latch sign = SIGNED_IN & int_i[31].
  - mag (32b) = sign ? -int_i : int_i. -2^31 gives mag = 0x80000000.
  - Clear shift count sc (5b).
  - If int_i == 0: fp_o = 0x0000, flag_o = 000, go to DONE. Otherwise go to NORM.
- NORM, one check per cycle:
  - mag[31] = 1: go to ROUND.
  - Else if mag[31:24] == 0: mag <<= 8, sc += 8.
  - Else: mag <<= 1, sc += 1.
- ROUND:
  - exp = 158 - sc. mant = mag[30:24], guard g = mag[23], sticky s = |mag[22:0].
  - Round up when g && (s || mant[0]). A mantissa carry sets mant = 0 and exp += 1.
  - fp_o = {sign, exp, mant}. flag_o = (g | s) ? 100 : 000. Go to DONE.
  - exp never exceeds 158 (signed) or 159 (unsigned), so there is no overflow or underflow.
- DONE:
  - fp_o and flag_o stay stable while out_ready_i = 0.
  - On out_ready_i = 1, go to IDLE. in_ready_o rises the next cycle. There is no same-cycle bypass.
- Latency, counted from the accept edge to out_valid_o high:
  - Zero operand: 1 cycle.
  - Otherwise: N_norm + 2 cycles, where N_norm counts NORM cycles including the final detect cycle.
  - Worst case is int_i = 1: 3 byte-shifts + 7 single shifts + 1 detect = 11 NORM cycles, so 13 cycles.
- Boundary rules:
  - in_valid_i outside IDLE is ignored; the operand is not consumed.
  - rst_i in any state returns to IDLE, discards the in-flight operand, and zeroes the outputs.
  - SIGNED_IN = 0 with int_i = 0xFFFFFFFF rounds to 2^32 = 0x4F80, flag 100.

Optional Feature:
- INT_TO_FP_LZC_EN defined:
  - NORM uses a single-cycle 32-bit leading-zero counter and performs the full left shift in exactly one cycle.
  - Nonzero latency is fixed at 3 cycles. Zero latency stays at 1.
  - Results and flags are bit-identical to the build without the macro.
- Not defined: the iterative 8/1-bit shifting described above.

Test Plan:
- int_i = 1, out_ready_i = 1 -> fp_o = 0x3F80, flag 000, out_valid_o 13 cycles after accept (3 with INT_TO_FP_LZC_EN).
- int_i = 0x80000000, SIGNED_IN = 1 -> fp_o = 0xCF00, flag 000, latency 3. int_i = 0 -> 0x0000, flag 000, latency 1.
- int_i = 0x7FFFFFFF -> fp_o = 0x4F00 (carry into exponent), flag 100, latency 4.
- Ties to even:
  - int_i = 257 -> 0x4380, flag 100.
  - int_i = 259 -> 0x4382, flag 100.
  - int_i = -257 -> 0xC380.
- Hold out_ready_i = 0 for 20 cycles in DONE -> fp_o/flag_o stable, in_ready_o = 0, a new in_valid_i is not consumed. Release out_ready_i -> in_ready_o = 1 the next cycle.
- Assert rst_i during NORM -> next cycle state IDLE, out_valid_o = 0, fp_o = 0. The following conversion of 3 -> 0x4040 is correct.
